// File: rtl/bp_me_axi_sram_subordinate.sv
// Single-beat AXI4 subordinate in front of a 64-bit word SRAM.
// One transaction is in flight at a time; reads and writes alternate under contention.
module bp_me_axi_sram_subordinate
  #(parameter s_axi_data_width_p = 64
   ,parameter s_axi_addr_width_p = 64
   ,parameter s_axi_id_width_p   = 1
   ,parameter els_p              = 1024
   ,parameter base_addr_p        = 0
   )
   (input  logic                            clk_i
   ,input  logic                            reset_i

   ,input  logic [s_axi_addr_width_p-1:0]   s_axi_awaddr_i
   ,input  logic                            s_axi_awvalid_i
   ,output logic                            s_axi_awready_o
   ,input  logic [s_axi_id_width_p-1:0]     s_axi_awid_i
   ,input  logic [7:0]                      s_axi_awlen_i
   ,input  logic [2:0]                      s_axi_awsize_i
   ,input  logic [1:0]                      s_axi_awburst_i
   ,input  logic                            s_axi_awlock_i
   ,input  logic [3:0]                      s_axi_awcache_i
   ,input  logic [2:0]                      s_axi_awprot_i
   ,input  logic [3:0]                      s_axi_awqos_i
   ,input  logic [3:0]                      s_axi_awregion_i

   ,input  logic [s_axi_data_width_p-1:0]   s_axi_wdata_i
   ,input  logic [s_axi_data_width_p/8-1:0] s_axi_wstrb_i
   ,input  logic                            s_axi_wlast_i
   ,input  logic                            s_axi_wvalid_i
   ,output logic                            s_axi_wready_o

   ,output logic [s_axi_id_width_p-1:0]     s_axi_bid_o
   ,output logic [1:0]                      s_axi_bresp_o
   ,output logic                            s_axi_bvalid_o
   ,input  logic                            s_axi_bready_i

   ,input  logic [s_axi_addr_width_p-1:0]   s_axi_araddr_i
   ,input  logic                            s_axi_arvalid_i
   ,output logic                            s_axi_arready_o
   ,input  logic [s_axi_id_width_p-1:0]     s_axi_arid_i
   ,input  logic [7:0]                      s_axi_arlen_i
   ,input  logic [2:0]                      s_axi_arsize_i
   ,input  logic [1:0]                      s_axi_arburst_i
   ,input  logic                            s_axi_arlock_i
   ,input  logic [3:0]                      s_axi_arcache_i
   ,input  logic [2:0]                      s_axi_arprot_i
   ,input  logic [3:0]                      s_axi_arqos_i
   ,input  logic [3:0]                      s_axi_arregion_i

   ,output logic [s_axi_data_width_p-1:0]   s_axi_rdata_o
   ,output logic [1:0]                      s_axi_rresp_o
   ,output logic                            s_axi_rlast_o
   ,output logic [s_axi_id_width_p-1:0]     s_axi_rid_o
   ,output logic                            s_axi_rvalid_o
   ,input  logic                            s_axi_rready_i
   );

   localparam int unsigned idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int unsigned strb_width_lp = s_axi_data_width_p / 8;

   localparam logic [s_axi_addr_width_p-1:0] base_lp  = s_axi_addr_width_p'(base_addr_p);
   localparam logic [s_axi_addr_width_p-1:0] limit_lp = base_lp + s_axi_addr_width_p'(8 * els_p);

   localparam logic [1:0] resp_okay_lp   = 2'b00;
   localparam logic [1:0] resp_decerr_lp = 2'b11;

   localparam logic [2:0] e_ready = 3'd0;
   localparam logic [2:0] e_write = 3'd1;
   localparam logic [2:0] e_wresp = 3'd2;
   localparam logic [2:0] e_read  = 3'd3;
   localparam logic [2:0] e_rdata = 3'd4;

   logic [2:0] state_q, state_d;
   logic       aw_full_q, aw_full_d;
   logic       w_full_q, w_full_d;
   logic       last_served_q, last_served_d;

   logic [s_axi_addr_width_p-1:0] awaddr_q;
   logic [s_axi_id_width_p-1:0]   awid_q;
   logic [s_axi_data_width_p-1:0] wdata_q;
   logic [strb_width_lp-1:0]      wstrb_q;
   logic [s_axi_addr_width_p-1:0] araddr_q;
   logic [s_axi_id_width_p-1:0]   arid_q;

   logic [s_axi_data_width_p-1:0] rdata_q;
   logic [1:0]                    rresp_q;
   logic [1:0]                    bresp_q;

   logic [s_axi_data_width_p-1:0] mem_q [els_p];

   logic in_ready, read_sel, write_idle;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

   logic [s_axi_addr_width_p-1:0] aw_offset, ar_offset;
   logic [idx_width_lp-1:0]       aw_idx, ar_idx;
   logic                          aw_in_range, ar_in_range;

   // Reads win only when the write side is completely quiet, or when the last
   // response was a write and nothing has been captured yet (fair alternation).
   assign in_ready   = (state_q == e_ready) & ~reset_i;
   assign write_idle = ~aw_full_q & ~w_full_q;
   assign read_sel   = s_axi_arvalid_i
                     & write_idle
                     & ((~s_axi_awvalid_i & ~s_axi_wvalid_i) | last_served_q);

   assign s_axi_awready_o = in_ready & ~read_sel & ~aw_full_q;
   assign s_axi_wready_o  = in_ready & ~read_sel & ~w_full_q;
   assign s_axi_arready_o = in_ready & read_sel;

   assign s_axi_bvalid_o = (state_q == e_wresp) & ~reset_i;
   assign s_axi_bresp_o  = bresp_q;
   assign s_axi_bid_o    = awid_q;

   assign s_axi_rvalid_o = (state_q == e_rdata) & ~reset_i;
   assign s_axi_rlast_o  = (state_q == e_rdata);
   assign s_axi_rdata_o  = rdata_q;
   assign s_axi_rresp_o  = rresp_q;
   assign s_axi_rid_o    = arid_q;

   assign aw_hs = s_axi_awvalid_i & s_axi_awready_o;
   assign w_hs  = s_axi_wvalid_i  & s_axi_wready_o;
   assign ar_hs = s_axi_arvalid_i & s_axi_arready_o;
   assign b_hs  = s_axi_bvalid_o  & s_axi_bready_i;
   assign r_hs  = s_axi_rvalid_o  & s_axi_rready_i;

   assign aw_offset   = awaddr_q - base_lp;
   assign ar_offset   = araddr_q - base_lp;
   assign aw_idx      = aw_offset[3 +: idx_width_lp];
   assign ar_idx      = ar_offset[3 +: idx_width_lp];
   assign aw_in_range = (awaddr_q >= base_lp) && (awaddr_q < limit_lp);
   assign ar_in_range = (araddr_q >= base_lp) && (araddr_q < limit_lp);

   always_comb begin
      aw_full_d     = b_hs ? 1'b0 : (aw_full_q | aw_hs);
      w_full_d      = b_hs ? 1'b0 : (w_full_q | w_hs);
      last_served_d = last_served_q;
      if (b_hs)
         last_served_d = 1'b1;
      else if (r_hs)
         last_served_d = 1'b0;

      state_d = state_q;
      case (state_q)
         e_ready: begin
            if (ar_hs)
               state_d = e_read;
            else if (aw_full_d & w_full_d)
               state_d = e_write;
         end
         e_write: state_d = e_wresp;
         e_wresp: if (s_axi_bready_i) state_d = e_ready;
         e_read:  state_d = e_rdata;
         e_rdata: if (s_axi_rready_i) state_d = e_ready;
         default: state_d = e_ready;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= e_ready;
         aw_full_q     <= 1'b0;
         w_full_q      <= 1'b0;
         last_served_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         aw_full_q     <= aw_full_d;
         w_full_q      <= w_full_d;
         last_served_q <= last_served_d;
      end
   end

   // Holding registers and response payloads carry no reset; valids qualify them.
   always_ff @(posedge clk_i) begin
      if (aw_hs) begin
         awaddr_q <= s_axi_awaddr_i;
         awid_q   <= s_axi_awid_i;
      end
      if (w_hs) begin
         wdata_q <= s_axi_wdata_i;
         wstrb_q <= s_axi_wstrb_i;
      end
      if (ar_hs) begin
         araddr_q <= s_axi_araddr_i;
         arid_q   <= s_axi_arid_i;
      end
      if (state_q == e_write)
         bresp_q <= aw_in_range ? resp_okay_lp : resp_decerr_lp;
      if (state_q == e_read) begin
         rresp_q <= ar_in_range ? resp_okay_lp : resp_decerr_lp;
         rdata_q <= ar_in_range ? mem_q[ar_idx] : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if ((state_q == e_write) && aw_in_range) begin
         for (int b = 0; b < strb_width_lp; b++) begin
            if (wstrb_q[b])
               mem_q[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   logic unused_sideband;
   assign unused_sideband = ^{s_axi_awlen_i, s_axi_awsize_i, s_axi_awburst_i, s_axi_awlock_i,
                              s_axi_awcache_i, s_axi_awprot_i, s_axi_awqos_i, s_axi_awregion_i,
                              s_axi_wlast_i, s_axi_arlen_i, s_axi_arsize_i, s_axi_arburst_i,
                              s_axi_arlock_i, s_axi_arcache_i, s_axi_arprot_i, s_axi_arqos_i,
                              s_axi_arregion_i, aw_offset, ar_offset};

   // Bursts are not supported; only single-beat requests may be presented.
   awlen_single: assert property (@(posedge clk_i) disable iff (reset_i)
                                  aw_hs |-> (s_axi_awlen_i == 8'd0))
      else $error("awlen must be zero");
   arlen_single: assert property (@(posedge clk_i) disable iff (reset_i)
                                  ar_hs |-> (s_axi_arlen_i == 8'd0))
      else $error("arlen must be zero");

endmodule

// File: tb/tb_bp_me_axi_sram_subordinate.sv
// Randomized bench for the AXI SRAM subordinate against a word-array memory model.
module tb_bp_me_axi_sram_subordinate;

   localparam int          ELS   = 64;
   localparam logic [63:0] BASE  = 64'h100;
   localparam logic [63:0] LIMIT = BASE + 64'(8 * ELS);

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic [63:0] awaddr = '0;
   logic        awvalid = 1'b0, awready;
   logic        awid = 1'b0;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        wvalid = 1'b0, wready;
   logic        bid;
   logic [1:0]  bresp;
   logic        bvalid, bready = 1'b0;
   logic [63:0] araddr = '0;
   logic        arvalid = 1'b0, arready;
   logic        arid = 1'b0;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rid, rvalid, rready = 1'b0;

   int total = 0;
   int bad = 0;

   logic [63:0] model [ELS];

   always #5 clk = ~clk;

   bp_me_axi_sram_subordinate #(
      .s_axi_data_width_p(64), .s_axi_addr_width_p(64), .s_axi_id_width_p(1),
      .els_p(ELS), .base_addr_p(256)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready),
      .s_axi_awid_i(awid), .s_axi_awlen_i(8'd0), .s_axi_awsize_i(3'd3), .s_axi_awburst_i(2'b01),
      .s_axi_awlock_i(1'b0), .s_axi_awcache_i(4'd0), .s_axi_awprot_i(3'd0),
      .s_axi_awqos_i(4'd0), .s_axi_awregion_i(4'd0),
      .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(1'b1),
      .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready),
      .s_axi_bid_o(bid), .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
      .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
      .s_axi_arid_i(arid), .s_axi_arlen_i(8'd0), .s_axi_arsize_i(3'd3), .s_axi_arburst_i(2'b01),
      .s_axi_arlock_i(1'b0), .s_axi_arcache_i(4'd0), .s_axi_arprot_i(3'd0),
      .s_axi_arqos_i(4'd0), .s_axi_arregion_i(4'd0),
      .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rlast_o(rlast),
      .s_axi_rid_o(rid), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic bit modelInRange(input logic [63:0] addr);
      return (addr >= BASE) && (addr < LIMIT);
   endfunction

   function automatic logic [63:0] modelRead(input logic [63:0] addr);
      if (!modelInRange(addr)) return 64'd0;
      return model[int'((addr - BASE) >> 3)];
   endfunction

   task automatic modelWrite(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             output logic [1:0] resp);
      int idx;
      if (!modelInRange(addr)) begin
         resp = 2'b11;
         return;
      end
      idx = int'((addr - BASE) >> 3);
      for (int b = 0; b < 8; b++)
         if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      resp = 2'b00;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      #1;
      checkOutput("rst_readies", {awready, wready, arready}, 3'b000);
      checkOutput("rst_valids", {bvalid, rvalid}, 2'b00);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_readies", {awready, wready, arready}, 3'b110);
      checkOutput("post_rst_valids", {bvalid, rvalid}, 2'b00);
   endtask

   // Called just after the clock edge on which the write became complete.
   task automatic awaitB(input logic idExp, input logic [1:0] respExp, input int hold);
      @(negedge clk);
      checkOutput("b_early", bvalid, 1'b0);
      @(negedge clk);
      checkOutput("b_latency", bvalid, 1'b1);
      for (int i = 0; i < hold; i++) begin
         checkOutput("b_hold_readies", {awready, wready, arready}, 3'b000);
         @(negedge clk);
         checkOutput("b_stable", {bvalid, bid, bresp}, {1'b1, idExp, respExp});
      end
      bready = 1'b1;
      #1;
      checkOutput("bresp", bresp, respExp);
      checkOutput("bid", bid, idExp);
      @(posedge clk); #1;
      bready = 1'b0;
   endtask

   task automatic awaitR(input logic [63:0] expData, input logic [1:0] expResp, input logic idExp, input int hold);
      @(negedge clk);
      checkOutput("r_early", rvalid, 1'b0);
      @(negedge clk);
      checkOutput("r_latency", rvalid, 1'b1);
      for (int i = 0; i < hold; i++) begin
         checkOutput("r_hold_readies", {awready, wready, arready}, 3'b000);
         @(negedge clk);
         checkOutput("r_stable", {rvalid, rid, rresp}, {1'b1, idExp, expResp});
         checkOutput("r_stable_data", rdata, expData);
      end
      rready = 1'b1;
      #1;
      checkOutput("rdata", rdata, expData);
      checkOutput("rresp", rresp, expResp);
      checkOutput("rlast", rlast, 1'b1);
      checkOutput("rid", rid, idExp);
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic doWrite(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input logic id, input int awDelay, input int wDelay, input int bHold);
      bit awDone = 0;
      bit wDone = 0;
      bit awHs, wHs;
      int cyc = 0;
      logic [1:0] expResp;
      awaddr = addr; awid = id; wdata = data; wstrb = strb;
      while (!(awDone && wDone)) begin
         @(negedge clk);
         if (!awDone && cyc >= awDelay) awvalid = 1'b1;
         if (!wDone && cyc >= wDelay) wvalid = 1'b1;
         #1;
         if (wDone && !awDone) checkOutput("w_held_wready", wready, 1'b0);
         if (awDone && !wDone) checkOutput("aw_held_awready", awready, 1'b0);
         awHs = awvalid & awready;
         wHs  = wvalid & wready;
         @(posedge clk); #1;
         if (awHs) begin awDone = 1; awvalid = 1'b0; end
         if (wHs) begin wDone = 1; wvalid = 1'b0; end
         cyc++;
         if (cyc > 40) begin
            checkOutput("wr_timeout", 1'b0, 1'b1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
         end
      end
      modelWrite(addr, data, strb, expResp);
      awaitB(id, expResp, bHold);
   endtask

   task automatic readCore(input logic [63:0] addr, input logic id, input int hold,
                           input logic [63:0] expData, input logic [1:0] expResp);
      bit hs;
      int cyc = 0;
      araddr = addr; arid = id;
      do begin
         @(negedge clk);
         arvalid = 1'b1;
         #1;
         hs = arready;
         @(posedge clk); #1;
         cyc++;
         if (cyc > 40) begin
            checkOutput("rd_timeout", 1'b0, 1'b1);
            arvalid = 1'b0;
            return;
         end
      end while (!hs);
      arvalid = 1'b0;
      awaitR(expData, expResp, id, hold);
   endtask

   task automatic doRead(input logic [63:0] addr, input logic id, input int hold);
      readCore(addr, id, hold, modelRead(addr), modelInRange(addr) ? 2'b00 : 2'b11);
   endtask

   task automatic applyStimulus();
      logic [1:0]  resp;
      logic [63:0] addr, data;
      logic [7:0]  strb;
      int sel;

      applyReset();
      for (int i = 0; i < ELS; i++)
         doWrite(BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 1'b0, 0, 0, 0);

      // Basic write then read back
      doWrite(BASE + 64'h10, 64'h1122334455667788, 8'hFF, 1'b0, 0, 0, 0);
      readCore(BASE + 64'h10, 1'b0, 0, 64'h1122334455667788, 2'b00);

      // W arrives three cycles before AW; partial strobe merges into prior word
      doWrite(BASE + 64'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b1, 3, 0, 0);
      readCore(BASE + 64'h10, 1'b1, 0, 64'h11223344_BBBBBBBB, 2'b00);

      // Out of range at the limit: DECERR and no aliasing onto word 0
      doRead(LIMIT, 1'b1, 0);
      checkOutput("oor_model", modelInRange(LIMIT), 1'b0);
      doWrite(LIMIT, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 0, 0, 1);
      doRead(BASE, 1'b0, 0);
      doRead(BASE - 64'h8, 1'b0, 0);

      // Long R backpressure
      doRead(BASE + 64'h28, 1'b1, 5);

      // Contention from reset: write first, then read
      applyReset();
      @(negedge clk);
      araddr = BASE + 64'h8; arid = 1'b1; arvalid = 1'b1;
      awaddr = BASE + 64'h18; awid = 1'b0; awvalid = 1'b1;
      wdata = 64'h0123456789ABCDEF; wstrb = 8'hFF; wvalid = 1'b1;
      #1;
      checkOutput("arb1_readies", {awready, wready, arready}, 3'b110);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      modelWrite(BASE + 64'h18, 64'h0123456789ABCDEF, 8'hFF, resp);
      awaitB(1'b0, 2'b00, 1);
      @(negedge clk); #1;
      checkOutput("arb1_arready", arready, 1'b1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      awaitR(model[1], 2'b00, 1'b1, 0);

      // Contention after a write: read first, then write
      doWrite(BASE + 64'h30, 64'h5555AAAA5555AAAA, 8'hFF, 1'b0, 0, 0, 0);
      @(negedge clk);
      araddr = BASE + 64'h30; arid = 1'b1; arvalid = 1'b1;
      awaddr = BASE + 64'h30; awid = 1'b0; awvalid = 1'b1;
      wdata = 64'h0F0F0F0F0F0F0F0F; wstrb = 8'hF0; wvalid = 1'b1;
      #1;
      checkOutput("arb2_readies", {awready, wready, arready}, 3'b001);
      @(posedge clk); #1;
      arvalid = 1'b0;
      awaitR(64'h5555AAAA5555AAAA, 2'b00, 1'b1, 1);
      @(negedge clk); #1;
      checkOutput("arb2_wr_readies", {awready, wready, arready}, 3'b110);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      modelWrite(BASE + 64'h30, 64'h0F0F0F0F0F0F0F0F, 8'hF0, resp);
      awaitB(1'b0, resp, 0);
      doRead(BASE + 64'h30, 1'b0, 0);

      // Reset while a write response is pending
      @(negedge clk);
      awaddr = BASE + 64'h40; awid = 1'b1; awvalid = 1'b1;
      wdata = 64'h7777666655554444; wstrb = 8'hFF; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      modelWrite(BASE + 64'h40, 64'h7777666655554444, 8'hFF, resp);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_mid_bvalid_before", bvalid, 1'b1);
      reset = 1'b1;
      #1;
      checkOutput("rst_mid_bvalid_now", bvalid, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_bvalid_after", bvalid, 1'b0);
      checkOutput("rst_mid_readies", {awready, wready, arready}, 3'b110);
      doRead(BASE + 64'h40, 1'b0, 0);

      // Randomized mix
      for (int n = 0; n < 120; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      addr = BASE - 64'(8 * $urandom_range(1, 4));
         else if (sel == 1) addr = LIMIT + 64'(8 * $urandom_range(0, 3));
         else               addr = BASE + 64'(8 * $urandom_range(0, ELS - 1)) + 64'($urandom_range(0, 7));
         data = {$urandom, $urandom};
         strb = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 1) == 0)
            doWrite(addr, data, strb, 1'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         else
            doRead(addr, 1'($urandom), int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      applyStimulus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
